iter_divider: RTL and testbench

- Multi-cycle radix-2 restoring divider for the EXE stage. Executes MIPS DIV and DIVU.
- Produces `div_busy`, which the hazard/bypass logic combines with the ID-stage DIV decode to stall the front end.
- Delivers quotient/remainder with a one-cycle `div_done` strobe that serves as the LO/HI write enable.
- An exception/interrupt flush cancels an in-flight division.

---
 rtl/iter_divider.sv | 159 +++++++++++++++
 tb/tb_iter_divider.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// ---------------------------------------------------------------------------
// iter_divider
//   Multi-cycle radix-2 restoring divider for the EXE stage (MIPS DIV/DIVU).
//   One quotient bit per cycle, MSB first; DW iterations per operation.
//
// Ports
//   clk, rst           : rising-edge clock, synchronous active-high reset
//   div_start          : single-cycle launch pulse from EXE
//   div_signed         : 1 = DIV (two's complement), 0 = DIVU
//   dividend, divisor  : rs / rt operands, sampled with div_start
//   ex_int_handle      : pipeline flush, cancels any in-flight operation
//   div_busy           : operation in progress (to stall logic)
//   div_done           : one-cycle strobe, results valid (LO/HI write enable)
//   quotient           : registered quotient  (LO)
//   remainder          : registered remainder (HI)
// ---------------------------------------------------------------------------
module iter_divider #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          div_start,
    input  logic          div_signed,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    input  logic          ex_int_handle,
    output logic          div_busy,
    output logic          div_done,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Launch request, formed combinationally from the EXE operands.
    typedef struct packed {
        logic [DW-1:0] a_abs;
        logic [DW-1:0] b_abs;
        logic          q_neg;
        logic          r_neg;
    } div_req_t;

    state_t        state;
    state_t        state_nxt;
    logic [5:0]    cnt;

    // dvd_sh starts as |a|; dividend bits shift out of the top while
    // quotient bits shift in at the bottom, so after DW steps it holds q.
    logic [DW-1:0] dvd_sh;
    logic [DW-1:0] dsr_abs;
    logic [DW-1:0] prem;
    logic          q_neg;
    logic          r_neg;

    div_req_t      req;
    logic          accept;
    logic          last_iter;

    logic [DW:0]   partial;
    logic [DW:0]   trial;
    logic          q_bit;
    logic [DW-1:0] prem_nxt;
    logic [DW-1:0] dvd_nxt;
    logic [DW-1:0] q_final;
    logic [DW-1:0] r_final;

    // -----------------------------------------------------------------------
    // Operand conditioning. |0x80000000| wraps to 0x80000000, which is the
    // correct magnitude when treated as unsigned.
    // -----------------------------------------------------------------------
    always_comb begin
        req       = '0;
        req.a_abs = (div_signed && dividend[DW-1]) ? (DW'(0) - dividend) : dividend;
        req.b_abs = (div_signed && divisor[DW-1])  ? (DW'(0) - divisor)  : divisor;
        req.q_neg = div_signed & (dividend[DW-1] ^ divisor[DW-1]);
        req.r_neg = div_signed & dividend[DW-1];
    end

    // Starts are only honoured from IDLE or DONE; a flush in the same cycle wins.
    assign accept    = div_start & ~ex_int_handle & (state != BUSY);
    assign last_iter = (state == BUSY) && (cnt == 6'(DW - 1));

    // -----------------------------------------------------------------------
    // One restoring step. The partial remainder is always < |b| (or b == 0),
    // so the DW+1 bit difference is negative exactly when its top bit is set.
    // With b == 0 every step succeeds, giving q = all ones and r = |a|.
    // -----------------------------------------------------------------------
    always_comb begin
        partial  = {prem, dvd_sh[DW-1]};
        trial    = partial - {1'b0, dsr_abs};
        q_bit    = ~trial[DW];
        prem_nxt = q_bit ? trial[DW-1:0] : partial[DW-1:0];
        dvd_nxt  = {dvd_sh[DW-2:0], q_bit};
        q_final  = q_neg ? (DW'(0) - dvd_nxt)  : dvd_nxt;
        r_final  = r_neg ? (DW'(0) - prem_nxt) : prem_nxt;
    end

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (ex_int_handle) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (div_start) state_nxt = BUSY;
                BUSY:    if (last_iter) state_nxt = DONE;
                DONE:    state_nxt = div_start ? BUSY : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Datapath. Results are written only on a completed final iteration, so
    // a flush or reset never produces a partial LO/HI update.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            dvd_sh    <= '0;
            dsr_abs   <= '0;
            prem      <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (accept) begin
            cnt     <= '0;
            dvd_sh  <= req.a_abs;
            dsr_abs <= req.b_abs;
            prem    <= '0;
            q_neg   <= req.q_neg;
            r_neg   <= req.r_neg;
        end else if (state == BUSY && !ex_int_handle) begin
            cnt    <= cnt + 6'd1;
            dvd_sh <= dvd_nxt;
            prem   <= prem_nxt;
            if (last_iter) begin
                quotient  <= q_final;
                remainder <= r_final;
            end
        end
    end

    assign div_busy = (state == BUSY);
    assign div_done = (state == DONE);

endmodule

// File: tb/tb_iter_divider.sv
// ---------------------------------------------------------------------------
// tb_iter_divider
//   Directed self-checking bench for iter_divider (DW = 32). Inputs change on
//   the falling edge; outputs are sampled on the falling edge. Cycle 1 is the
//   first falling edge after the edge that samples div_start.
// ---------------------------------------------------------------------------
module tb_iter_divider;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          div_start;
    logic          div_signed;
    logic [DW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic          ex_int_handle;
    logic          div_busy;
    logic          div_done;
    logic [DW-1:0] quotient;
    logic [DW-1:0] remainder;

    int n_chk = 0;
    int n_err = 0;

    iter_divider #(.DW(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .div_start     (div_start),
        .div_signed    (div_signed),
        .dividend      (dividend),
        .divisor       (divisor),
        .ex_int_handle (ex_int_handle),
        .div_busy      (div_busy),
        .div_done      (div_done),
        .quotient      (quotient),
        .remainder     (remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive a start pulse; called at a falling edge, returns at cycle 1.
    task automatic issue(input logic sgn, input logic [DW-1:0] a, input logic [DW-1:0] b);
        div_start  = 1'b1;
        div_signed = sgn;
        dividend   = a;
        divisor    = b;
        @(negedge clk);
        div_start  = 1'b0;
    endtask

    // From cycle 1, wait for div_done; reports its cycle and busy-cycle count.
    // cyc = 0 means the bound expired.
    task automatic wait_done(output int cyc, output int busy_n);
        int k;
        cyc    = 0;
        busy_n = 0;
        k      = 1;
        while (k <= 60) begin
            if (div_done) begin
                cyc = k;
                break;
            end
            if (div_busy) busy_n++;
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_div(input string tag, input logic sgn,
                           input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] eq, input logic [DW-1:0] er);
        int cyc, bn;
        issue(sgn, a, b);
        wait_done(cyc, bn);
        chk({tag, "_lat"},  DW'(cyc), DW'(33));
        chk({tag, "_busy"}, DW'(bn),  DW'(32));
        chk({tag, "_q"},    quotient,  eq);
        chk({tag, "_r"},    remainder, er);
        @(negedge clk);
    endtask

    initial begin
        int cyc, bn, done_seen;

        rst           = 1'b1;
        div_start     = 1'b0;
        div_signed    = 1'b0;
        dividend      = '0;
        divisor       = '0;
        ex_int_handle = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_busy", DW'(div_busy), 0);
        chk("rst_done", DW'(div_done), 0);
        chk("rst_q",    quotient,      0);
        chk("rst_r",    remainder,     0);

        // 1. Basic DIVU latency
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        chk("post_busy", DW'(div_busy), 0);
        chk("post_done", DW'(div_done), 0);
        chk("hold_q", quotient, 32'd14);

        // 2. Signed results
        run_div("div_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("div_7_m2",   1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_div("divu_ff_2",  1'b0, 32'hFFFF_FFFF, 32'd2,        32'h7FFF_FFFF, 32'd1);

        // 3. Corners
        run_div("div_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_div("divu_5_0",   1'b0, 32'd5,         32'd0,        32'hFFFF_FFFF, 32'd5);
        run_div("div_min_1",  1'b1, 32'h8000_0000, 32'd1,        32'h8000_0000, 32'd0);
        run_div("div_7_0",    1'b1, 32'd7,         32'd0,        32'hFFFF_FFFF, 32'd7);
        run_div("div_m7_0",   1'b1, 32'hFFFF_FFF9, 32'd0,        32'h0000_0001, 32'hFFFF_FFF9);

        // 4. Cancel mid-operation
        run_div("pre_cancel", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        issue(1'b0, 32'd50, 32'd3);
        repeat (9) @(negedge clk);       // now at cycle 10
        chk("cancel_busy_pre", DW'(div_busy), 1);
        ex_int_handle = 1'b1;
        @(negedge clk);
        ex_int_handle = 1'b0;
        chk("cancel_busy", DW'(div_busy), 0);
        done_seen = 0;
        repeat (40) begin
            if (div_done || div_busy) done_seen++;
            @(negedge clk);
        end
        chk("cancel_nodone", DW'(done_seen), 0);
        chk("cancel_q", quotient,  32'd14);
        chk("cancel_r", remainder, 32'd2);

        // 5. Back-to-back: second start during the DONE cycle
        issue(1'b0, 32'd100, 32'd7);
        wait_done(cyc, bn);
        chk("b2b1_lat", DW'(cyc), 33);
        chk("b2b1_q", quotient,  32'd14);
        chk("b2b1_r", remainder, 32'd2);
        issue(1'b0, 32'd9, 32'd4);
        chk("b2b2_busy", DW'(div_busy), 1);
        wait_done(cyc, bn);
        chk("b2b2_lat", DW'(cyc), 33);
        chk("b2b2_q", quotient,  32'd2);
        chk("b2b2_r", remainder, 32'd1);
        @(negedge clk);

        // Start coincident with flush in IDLE is ignored
        ex_int_handle = 1'b1;
        issue(1'b0, 32'd77, 32'd5);
        ex_int_handle = 1'b0;
        chk("flush_start_busy", DW'(div_busy), 0);
        done_seen = 0;
        repeat (40) begin
            if (div_done || div_busy) done_seen++;
            @(negedge clk);
        end
        chk("flush_start_nodone", DW'(done_seen), 0);
        chk("flush_start_q", quotient, 32'd2);

        // 6. Reset mid-operation
        issue(1'b0, 32'd100, 32'd7);
        repeat (19) @(negedge clk);      // now at cycle 20
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_busy", DW'(div_busy), 0);
        chk("mrst_done", DW'(div_done), 0);
        chk("mrst_q",    quotient,      0);
        chk("mrst_r",    remainder,     0);
        @(negedge clk);
        chk("mrst_idle", DW'(div_busy), 0);
        run_div("after_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
